// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 7-segment scanner with frame-synchronous updates,
// per-digit blanking, blinking and decimal points.
module seg_scan_driver #(
   parameter int NUM_DIGITS   = 8,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [NUM_DIGITS-1:0]   blink_in,
   input  logic                    load,
   input  logic                    dec_mode,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    upd_pend,
   output logic                    frame_done
);
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int CW = $clog2(REFRESH_DIV);
   localparam int FW = $clog2(BLINK_FRAMES) + 1;
   localparam int BW = 7 * NUM_DIGITS;
   localparam logic [6:0] GLYPH [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;
   logic [FW-1:0] fcnt;
   logic          phase, valid, tc, wrap, dark;
   logic [3:0]    nib;
   logic [BW-1:0] in_buf, act_buf, pnd_buf;
   logic [4*NUM_DIGITS-1:0] act_dig;
   logic [NUM_DIGITS-1:0]   act_dp, act_blank, act_blink;

   // buffer layout: {digits, dp, blank, blink}
   assign in_buf = {digits_in, dp_in, blank_in, blink_in};
   assign {act_dig, act_dp, act_blank, act_blink} = act_buf;
   assign tc = cnt == CW'(REFRESH_DIV - 1);
   assign wrap = tc && idx == IW'(NUM_DIGITS - 1);
   assign frame_done = wrap;
   assign dark = act_blank[idx] | (act_blink[idx] & phase);
   assign nib = act_dig[{idx, 2'b00} +: 4];

   // valid stays low until the first commit after reset, so the scan runs dark
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         idx      <= '0;
         fcnt     <= '0;
         phase    <= 1'b0;
         valid    <= 1'b0;
         act_buf  <= '0;
         pnd_buf  <= '0;
         upd_pend <= 1'b0;
         an       <= '1;
         seg      <= '1;
         dp       <= 1'b1;
      end else begin
         cnt <= tc ? '0 : cnt + CW'(1);
         if (tc) idx <= wrap ? '0 : idx + IW'(1);
         if (load) pnd_buf <= in_buf;
         if (wrap) begin
            upd_pend <= 1'b0;
            if (load || upd_pend) begin
               act_buf <= load ? in_buf : pnd_buf;
               valid   <= 1'b1;
            end
            fcnt <= (fcnt == FW'(BLINK_FRAMES - 1)) ? '0 : fcnt + FW'(1);
            if (fcnt == FW'(BLINK_FRAMES - 1)) phase <= ~phase;
         end else if (load) begin
            upd_pend <= 1'b1;
         end
         an  <= dark ? '1 : ~(NUM_DIGITS'(1) << idx);
         seg <= (dark || !valid) ? '1 : (dec_mode && nib > 4'd9) ? 7'b1111110 : GLYPH[nib];
         dp  <= dark || !valid || !act_dp[idx];
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: random and directed stimulus against a cycle-count based
// reference model of the scanner.
module tb_seg_scan_driver;
   localparam int ND = 4, RD = 4, BF = 2, F = ND * RD;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] digits_in = '0;
   logic [3:0]  dp_in = '0, blank_in = '0, blink_in = '0;
   logic        load = 1'b0, dec_mode = 1'b0;
   logic [6:0]  seg;
   logic        dp, upd_pend, frame_done;
   logic [3:0]  an;

   seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
      .blank_in(blank_in), .blink_in(blink_in), .load(load), .dec_mode(dec_mode),
      .seg(seg), .dp(dp), .an(an), .upd_pend(upd_pend), .frame_done(frame_done));

   always #5 clk = ~clk;

   int vectors = 0, errors = 0;
   logic [6:0] glyph [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   // model: c counts clock edges since reset release; display state per frame
   int c;
   logic [15:0] m_dig, p_dig;
   logic [3:0]  m_dp, m_bk, m_bl, p_dp, p_bk, p_bl;
   bit          m_valid, m_pend;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at c=%0d: got %0h expected %0h", tag, c, got, exp);
      end
   endtask

   task automatic model_reset();
      c = 0; m_valid = 0; m_pend = 0;
      m_dig = '0; m_dp = '0; m_bk = '0; m_bl = '0;
      p_dig = '0; p_dp = '0; p_bk = '0; p_bl = '0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
   endtask

   // called at a negedge; applies inputs, checks, predicts, advances one clock
   task automatic step(input bit ld, input logic [15:0] d, input logic [3:0] dpv,
                       input logic [3:0] bkv, input logic [3:0] blv, input bit dm);
      int idx, ph, nib;
      bit dark, bnd;
      load = ld; digits_in = d; dp_in = dpv; blank_in = bkv; blink_in = blv; dec_mode = dm;
      bnd = ((c + 1) % F) == 0;
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("upd_pend", 32'(upd_pend), 32'(m_pend));
      check("frame_done", 32'(frame_done), 32'(bnd));
      idx = (c / RD) % ND;
      ph = ((c / F) / BF) % 2;
      dark = m_bk[idx] || (m_bl[idx] && ph == 1);
      nib = int'(m_dig[idx*4 +: 4]);
      e_an = dark ? 4'hF : ~(4'b0001 << idx);
      e_seg = (dark || !m_valid) ? 7'h7F : (dm && nib > 9) ? 7'b1111110 : glyph[nib];
      e_dp = dark || !m_valid || !m_dp[idx];
      if (bnd) begin
         if (ld) begin
            m_dig = d; m_dp = dpv; m_bk = bkv; m_bl = blv; m_valid = 1;
         end else if (m_pend) begin
            m_dig = p_dig; m_dp = p_dp; m_bk = p_bk; m_bl = p_bl; m_valid = 1;
         end
         m_pend = 0;
      end else if (ld) begin
         p_dig = d; p_dp = dpv; p_bk = bkv; p_bl = blv; m_pend = 1;
      end
      @(posedge clk);
      c++;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit dm);
      for (int i = 0; i < n; i++) step(0, 16'(($urandom)), 4'hF, 4'hF, 4'hF, dm);
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(2 * F, 0);
      // hex then decimal view of 12AF
      step(1, 16'h12AF, 4'h0, 4'h0, 4'h0, 0);
      idle(3 * F, 0);
      idle(2 * F, 1);
      // double load inside one frame: only the second one lands
      while (c % F != 5) idle(1, 0);
      step(1, 16'h1111, 4'h0, 4'h0, 4'h0, 0);
      idle(3, 0);
      step(1, 16'h2222, 4'h0, 4'h0, 4'h0, 0);
      idle(2 * F, 0);
      // blink / blank / decimal points
      step(1, 16'h8765, 4'b0101, 4'b0100, 4'b0001, 0);
      idle(8 * F, 0);
      // load coincident with frame boundary
      while ((c + 1) % F != 0) idle(1, 0);
      step(1, 16'h5A3C, 4'h3, 4'h0, 4'h0, 0);
      idle(2 * F, 1);
      // random traffic
      for (int i = 0; i < 50 * F; i++)
         step($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom),
              4'($urandom) & 4'($urandom) & 4'($urandom), 4'($urandom), $urandom_range(0, 1) == 1);
      // asynchronous reset mid-slot with a load pending
      while (c % F != 6) idle(1, 0);
      step(1, 16'h9999, 4'hF, 4'h0, 4'h0, 0);
      idle(1, 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_dp", 32'(dp), 32'h1);
      check("rst_upd_pend", 32'(upd_pend), 32'h0);
      check("rst_frame_done", 32'(frame_done), 32'h0);
      repeat (2) @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      idle(3 * F, 0);
      step(1, 16'h0000, 4'h0, 4'h0, 4'h0, 0);
      idle(2 * F, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
